plic_controller: RTL and testbench

- Platform-level interrupt controller for the RS5 SoC, memory-mapped on the core's data bus (window selected by address[31:28] in 3..7; 24-bit offset delivered here).
- Gathers `i_cnt` external interrupt lines into one machine-external interrupt, `irq_o`, which feeds the core's MEIP bit.
- Provides priorities, enables, threshold, claim and complete, plus per-source acknowledge.

---
 rtl/plic_pkg.sv | 19 +
 rtl/plic_gateway.sv | 31 +++
 rtl/plic_controller.sv | 163 ++++++++++++++++
 tb/tb_plic_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// Shared constants and helpers for the platform-level interrupt controller.
package plic_pkg;

   // Width of a source ID (IDs 1..31, 0 means "none").
   localparam int ID_W = 5;

   // Word offsets inside the 24-bit controller window.
   localparam logic [23:0] PRIO_BASE = 24'h000000;
   localparam logic [23:0] PEND_OFF  = 24'h001000;
   localparam logic [23:0] EN_OFF    = 24'h002000;
   localparam logic [23:0] THR_OFF   = 24'h200000;
   localparam logic [23:0] CLAIM_OFF = 24'h200004;

   // Expand the four byte enables into a 32-bit bit mask.
   function automatic logic [31:0] lane_mask(input logic [3:0] we);
      return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
   endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: holds pending and in-service for one interrupt source.
module plic_gateway (
   input  logic clk,
   input  logic reset,
   input  logic irq,
   input  logic claim,
   input  logic complete,
   output logic pending,
   output logic in_service
);

   // A request is latched only while the source is not in service; a claim
   // moves it from pending to in-service, a complete reopens the gateway.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending    <= 1'b0;
         in_service <= 1'b0;
      end else begin
         if (claim)
            pending <= 1'b0;
         else if (irq && !in_service)
            pending <= 1'b1;

         if (claim)
            in_service <= 1'b1;
         else if (complete)
            in_service <= 1'b0;
      end
   end

endmodule

// File: rtl/plic_controller.sv
// Platform-level interrupt controller: register file, gateways, arbitration
// and claim/complete handling for up to 31 level-sensitive sources.
module plic_controller
   import plic_pkg::*;
#(
   parameter int i_cnt  = 1,
   parameter int PRIO_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_i,
   input  logic [3:0]        we_i,
   input  logic [23:0]       addr_i,
   input  logic [31:0]       data_i,
   output logic [31:0]       data_o,
   input  logic [i_cnt-1:0]  irq_i,
   input  logic              iack_i,
   output logic [i_cnt-1:0]  iack_o,
   output logic              irq_o
);

   logic              bus_wr;
   logic              bus_rd;
   logic [23:0]       word_addr;
   logic              is_prio;
   logic [9:0]        prio_sel;
   logic [31:0]       wmask;
   logic [ID_W-1:0]   cid;
   logic              complete_hit;

   logic [PRIO_W-1:0] prio_arr [i_cnt];
   logic [i_cnt-1:0]  enable_reg;
   logic [PRIO_W-1:0] threshold_reg;
   logic [ID_W-1:0]   claim_id_reg;
   logic [31:0]       data_reg;
   logic [i_cnt-1:0]  iack_reg;
   logic              irq_reg;

   logic [i_cnt-1:0]  pending;
   logic [i_cnt-1:0]  in_service;
   logic [i_cnt-1:0]  claim_vec;
   logic [i_cnt-1:0]  complete_vec;

   logic [ID_W-1:0]   best_id;
   logic [PRIO_W-1:0] best_prio;
   logic [31:0]       rd_data;
   logic              do_claim;

   logic [i_cnt-1:0]  enable_next;
   logic [PRIO_W-1:0] threshold_next;

   assign bus_wr       = en_i && (we_i != 4'h0);
   assign bus_rd       = en_i && (we_i == 4'h0);
   assign word_addr    = {addr_i[23:2], 2'b00};
   assign is_prio      = (word_addr & 24'hFFF000) == PRIO_BASE;
   assign prio_sel     = addr_i[11:2];
   assign wmask        = lane_mask(we_i);
   assign cid          = data_i[ID_W-1:0];
   assign complete_hit = bus_wr && (word_addr == CLAIM_OFF);
   assign do_claim     = iack_i && (best_id != '0);

   // Byte-lane merges for the shared registers; bit 0 of enable is ID 0.
   assign enable_next    = (enable_reg & ~wmask[i_cnt:1]) | (data_i[i_cnt:1] & wmask[i_cnt:1]);
   assign threshold_next = (threshold_reg & ~wmask[PRIO_W-1:0])
                         | (data_i[PRIO_W-1:0] & wmask[PRIO_W-1:0]);

   // Address bits [1:0] and the upper data/mask bits have no function here.
   logic unused_bits;
   assign unused_bits = ^{addr_i[1:0], data_i, wmask};

   generate
      for (genvar gi = 0; gi < i_cnt; gi++) begin : g_src
         logic [PRIO_W-1:0] prio_reg;
         logic [PRIO_W-1:0] prio_next;

         assign prio_next = (prio_reg & ~wmask[PRIO_W-1:0])
                          | (data_i[PRIO_W-1:0] & wmask[PRIO_W-1:0]);
         assign prio_arr[gi] = prio_reg;

         // Priority of source ID gi+1, written through its own word.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               prio_reg <= '0;
            else if (bus_wr && is_prio && (prio_sel == 10'(gi + 1)))
               prio_reg <= prio_next;
         end

         assign claim_vec[gi]    = iack_i && (best_id == ID_W'(gi + 1));
         assign complete_vec[gi] = complete_hit && (cid == ID_W'(gi + 1)) && in_service[gi];

         plic_gateway u_gateway (
            .clk        (clk),
            .reset      (reset),
            .irq        (irq_i[gi]),
            .claim      (claim_vec[gi]),
            .complete   (complete_vec[gi]),
            .pending    (pending[gi]),
            .in_service (in_service[gi])
         );
      end
   endgenerate

   // Highest-priority enabled pending source; strict compare keeps the lowest ID on ties
   // and never selects a priority-0 source.
   always_comb begin
      best_id   = '0;
      best_prio = '0;
      for (int k = 0; k < i_cnt; k++) begin
         if (enable_reg[k] && pending[k] && (prio_arr[k] > best_prio)) begin
            best_prio = prio_arr[k];
            best_id   = ID_W'(k + 1);
         end
      end
   end

   // Read-data mux; anything unmapped reads zero.
   always_comb begin
      rd_data = '0;
      if (is_prio) begin
         for (int k = 0; k < i_cnt; k++)
            if (prio_sel == 10'(k + 1))
               rd_data = 32'(prio_arr[k]);
      end else if (word_addr == PEND_OFF)
         rd_data = 32'({pending, 1'b0});
      else if (word_addr == EN_OFF)
         rd_data = 32'({enable_reg, 1'b0});
      else if (word_addr == THR_OFF)
         rd_data = 32'(threshold_reg);
      else if (word_addr == CLAIM_OFF)
         rd_data = 32'(claim_id_reg);
   end

   // Enable, threshold and claim-id state plus the registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable_reg    <= '0;
         threshold_reg <= '0;
         claim_id_reg  <= '0;
         data_reg      <= '0;
         iack_reg      <= '0;
         irq_reg       <= 1'b0;
      end else begin
         if (bus_wr && (word_addr == EN_OFF))
            enable_reg <= enable_next;
         if (bus_wr && (word_addr == THR_OFF))
            threshold_reg <= threshold_next;
         // A new claim wins over clearing on complete of a different ID.
         if (do_claim)
            claim_id_reg <= best_id;
         else if ((|complete_vec) && (claim_id_reg == cid))
            claim_id_reg <= '0;
         if (bus_rd)
            data_reg <= rd_data;
         iack_reg <= claim_vec;
         irq_reg  <= best_prio > threshold_reg;
      end
   end

   assign data_o = data_reg;
   assign iack_o = iack_reg;
   assign irq_o  = irq_reg;

endmodule

// File: tb/tb_plic_controller.sv
// Self-checking bench for plic_controller with three sources.
module tb_plic_controller;

   localparam int N = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          en_i = 1'b0;
   logic [3:0]    we_i = 4'h0;
   logic [23:0]   addr_i = '0;
   logic [31:0]   data_i = '0;
   logic [31:0]   data_o;
   logic [N-1:0]  irq_i = '0;
   logic          iack_i = 1'b0;
   logic [N-1:0]  iack_o;
   logic          irq_o;

   int checks = 0;
   int errors = 0;

   plic_controller #(.i_cnt(N), .PRIO_W(3)) dut (
      .clk    (clk),
      .reset  (reset),
      .en_i   (en_i),
      .we_i   (we_i),
      .addr_i (addr_i),
      .data_i (data_i),
      .data_o (data_o),
      .irq_i  (irq_i),
      .iack_i (iack_i),
      .iack_o (iack_o),
      .irq_o  (irq_o)
   );

   always #5 clk = ~clk;

   // Scoreboard for bus reads: expectation pushed when the read is driven,
   // popped and compared when data_o has been registered.
   logic [31:0] exp_q [$];
   string       name_q [$];
   logic        rd_pending = 1'b0;
   logic [31:0] sb_exp;
   string       sb_name;

   always @(posedge clk) rd_pending <= en_i && (we_i == 4'h0);

   always @(negedge clk) begin
      if (rd_pending) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow got %h want nothing", data_o);
         end else begin
            sb_exp  = exp_q.pop_front();
            sb_name = name_q.pop_front();
            if (data_o !== sb_exp) begin
               errors++;
               $display("FAIL %s got %h want %h", sb_name, data_o, sb_exp);
            end else
               $display("read  %-24s got %h", sb_name, data_o);
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end else
         $display("check %-24s got %h", nm, act);
   endtask

   // All bus tasks start and end on a falling edge.
   task automatic bus_cycle(input logic [23:0] a, input logic [31:0] d, input logic [3:0] we);
      en_i = 1'b1; addr_i = a; data_i = d; we_i = we;
      @(negedge clk);
      en_i = 1'b0; we_i = 4'h0; data_i = '0;
   endtask

   task automatic wr(input logic [23:0] a, input logic [31:0] d);
      bus_cycle(a, d, 4'hF);
   endtask

   task automatic rd(input logic [23:0] a, input logic [31:0] exp, input string nm);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      bus_cycle(a, 32'h0, 4'h0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_iack();
      iack_i = 1'b1;
      @(negedge clk);
      iack_i = 1'b0;
   endtask

   typedef struct {
      logic [23:0] addr;
      logic [31:0] wdata;
      logic [3:0]  we;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [14];

   initial begin
      // write then read-back table: {offset, data, byte enables, expected readback}
      vecs[0]  = '{24'h000004, 32'h00000005, 4'hF, 32'h5};
      vecs[1]  = '{24'h002000, 32'h00000002, 4'hF, 32'h2};
      vecs[2]  = '{24'h200000, 32'h00000002, 4'hF, 32'h2};
      vecs[3]  = '{24'h000004, 32'hFFFFFF07, 4'h1, 32'h7};
      vecs[4]  = '{24'h000004, 32'h00000005, 4'h2, 32'h7};
      vecs[5]  = '{24'h000007, 32'h00000003, 4'hF, 32'h3};
      vecs[6]  = '{24'h000008, 32'h000000FF, 4'hF, 32'h7};
      vecs[7]  = '{24'h000000, 32'h00000007, 4'hF, 32'h0};
      vecs[8]  = '{24'h000010, 32'h00000007, 4'hF, 32'h0};
      vecs[9]  = '{24'h001000, 32'h0000FFFF, 4'hF, 32'h0};
      vecs[10] = '{24'h003000, 32'h00000001, 4'hF, 32'h0};
      vecs[11] = '{24'h002000, 32'hFFFFFFFF, 4'hF, 32'hE};
      vecs[12] = '{24'h200000, 32'h00000005, 4'hF, 32'h5};
      vecs[13] = '{24'h200004, 32'h00000000, 4'hF, 32'h0};

      // reset values
      idle(2);
      check("rst_irq_o", {31'b0, irq_o}, 32'h0);
      check("rst_iack_o", {29'b0, iack_o}, 32'h0);
      check("rst_data_o", data_o, 32'h0);
      reset = 1'b1;
      idle(1);

      // register access
      for (int i = 0; i < 14; i++) begin
         bus_cycle(vecs[i].addr, vecs[i].wdata, vecs[i].we);
         rd(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
      end
      wr(24'h000004, 32'h5);
      wr(24'h000008, 32'h0);
      wr(24'h002000, 32'h2);
      wr(24'h200000, 32'h2);

      // interrupt path
      irq_i = 3'b001;
      idle(1);
      rd(24'h001000, 32'h2, "pend_set");
      check("irq_on", {31'b0, irq_o}, 32'h1);
      wr(24'h200000, 32'h5);
      idle(1);
      check("irq_thr_mask", {31'b0, irq_o}, 32'h0);
      wr(24'h200000, 32'h2);
      idle(1);
      check("irq_thr_unmask", {31'b0, irq_o}, 32'h1);
      wr(24'h002000, 32'h0);
      idle(1);
      check("irq_en_mask", {31'b0, irq_o}, 32'h0);
      wr(24'h002000, 32'h2);
      idle(1);
      check("irq_en_unmask", {31'b0, irq_o}, 32'h1);

      // claim
      pulse_iack();
      check("iack_pulse", {29'b0, iack_o}, 32'h1);
      idle(1);
      check("iack_one_cycle", {29'b0, iack_o}, 32'h0);
      check("irq_drop", {31'b0, irq_o}, 32'h0);
      rd(24'h200004, 32'h1, "claim_id1");
      rd(24'h001000, 32'h0, "pend_blocked");

      // complete: gateway reopens one edge after the complete
      wr(24'h200004, 32'h1);
      rd(24'h001000, 32'h0, "pend_gate_edge");
      rd(24'h001000, 32'h2, "pend_reset");
      rd(24'h200004, 32'h0, "claim_cleared");

      // completing an ID that is not in service is ignored
      irq_i = 3'b000;
      pulse_iack();
      check("iack_reclaim", {29'b0, iack_o}, 32'h1);
      wr(24'h200004, 32'h3);
      rd(24'h200004, 32'h1, "claim_bad_complete");
      wr(24'h200004, 32'h1);
      rd(24'h200004, 32'h0, "claim_good_complete");
      rd(24'h001000, 32'h0, "pend_idle");

      // arbitration: ties to lowest ID, then the lower priority
      wr(24'h000004, 32'h4);
      wr(24'h000008, 32'h2);
      wr(24'h00000C, 32'h4);
      wr(24'h002000, 32'hE);
      wr(24'h200000, 32'h0);
      irq_i = 3'b111;
      idle(1);
      irq_i = 3'b000;
      idle(1);
      rd(24'h001000, 32'hE, "pend_all");
      check("irq_arb", {31'b0, irq_o}, 32'h1);
      pulse_iack();
      check("arb_first", {29'b0, iack_o}, 32'h1);
      rd(24'h200004, 32'h1, "arb_claim1");
      pulse_iack();
      check("arb_second", {29'b0, iack_o}, 32'h4);
      rd(24'h200004, 32'h3, "arb_claim3");
      pulse_iack();
      check("arb_third", {29'b0, iack_o}, 32'h2);
      rd(24'h200004, 32'h2, "arb_claim2");
      pulse_iack();
      check("arb_none", {29'b0, iack_o}, 32'h0);
      rd(24'h200004, 32'h2, "claim_kept");
      wr(24'h200004, 32'h1);
      wr(24'h200004, 32'h3);
      rd(24'h200004, 32'h2, "claim_other_done");
      wr(24'h200004, 32'h2);
      rd(24'h200004, 32'h0, "claim_all_done");

      // enable write in the same cycle as iack: arbitration sees the old enable
      irq_i = 3'b001;
      idle(1);
      irq_i = 3'b000;
      idle(1);
      iack_i = 1'b1;
      bus_cycle(24'h002000, 32'h0, 4'hF);
      iack_i = 1'b0;
      check("iack_prewrite", {29'b0, iack_o}, 32'h1);
      rd(24'h002000, 32'h0, "en_written");
      wr(24'h002000, 32'hE);
      wr(24'h200004, 32'h1);

      // asynchronous reset mid-run
      irq_i = 3'b001;
      idle(2);
      check("irq_before_reset", {31'b0, irq_o}, 32'h1);
      rd(24'h000004, 32'h4, "prio_before_reset");
      #2 reset = 1'b0;
      #1;
      check("mid_rst_irq_o", {31'b0, irq_o}, 32'h0);
      check("mid_rst_iack_o", {29'b0, iack_o}, 32'h0);
      check("mid_rst_data_o", data_o, 32'h0);
      irq_i = 3'b000;
      idle(1);
      reset = 1'b1;
      idle(1);
      rd(24'h000004, 32'h0, "rst_prio1");
      rd(24'h001000, 32'h0, "rst_pending");
      rd(24'h002000, 32'h0, "rst_enable");
      rd(24'h200000, 32'h0, "rst_threshold");
      rd(24'h200004, 32'h0, "rst_claim");
      idle(1);

      check("sb_drain", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
